// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state encoding and
// the M-extension decode helper.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00100;
    localparam logic [4:0] OP_OR     = 5'b00101;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_PASSA  = 5'b00111;
    localparam logic [4:0] OP_SHL    = 5'b01000;
    localparam logic [4:0] OP_SHR    = 5'b01010;
    localparam logic [4:0] OP_SHA    = 5'b01011;
    localparam logic [4:0] OP_SLT    = 5'b01100;
    localparam logic [4:0] OP_SLTU   = 5'b01101;
    localparam logic [4:0] OP_PASSB  = 5'b01111;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic is_mdu(input logic [4:0] op);
        return op[4];
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/writeback handshake bundle for seq_alu; the issue side is the master,
// the ALU is the slave.
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/seq_alu_iter_muldiv.sv
// Iterative radix-2 multiply/divide unit (XLEN steps per op); only built when
// SEQ_ALU_MDU_EN is defined.
`ifdef SEQ_ALU_MDU_EN
module iter_muldiv
    import seq_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = '1;

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == OP_MULH[2:0]) || (f == OP_MULHSU[2:0]) ||
               (f == OP_DIV[2:0])  || (f == OP_REM[2:0]);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == OP_MULH[2:0]) || (f == OP_DIV[2:0]) || (f == OP_REM[2:0]);
    endfunction

    logic                busy;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc_p0, acc_nxt, mul_step, div_step, prod;
    logic [XLEN-1:0]     dvs_p0, a_p0, a_mag, b_mag, quot, rem;
    logic [2:0]          op_p0;
    logic                a_neg, b_neg, a_neg_p0, b_neg_p0, dbz_p0, ovf_p0;
    logic [XLEN:0]       mul_sum, rem_ext, diff;

    // Operands are reduced to magnitudes; signs are reapplied after the last step.
    assign a_neg = a_is_signed(op) && a[XLEN-1];
    assign b_neg = b_is_signed(op) && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (cnt == CW'(XLEN-1)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // done coincides with the final step so the top registers it that same edge.
    assign done = busy && (cnt == CW'(XLEN-1));

    // Multiply: add multiplicand into the high half on LSB, shift right.
    assign mul_sum  = {1'b0, acc_p0[2*XLEN-1:XLEN]} + (acc_p0[0] ? {1'b0, dvs_p0} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_p0[XLEN-1:1]};

    // Restoring divide: shift left, trial-subtract, quotient bit enters at LSB.
    assign rem_ext  = acc_p0[2*XLEN-1:XLEN-1];
    assign diff     = rem_ext - {1'b0, dvs_p0};
    assign div_step = diff[XLEN] ? {rem_ext[XLEN-1:0], acc_p0[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],    acc_p0[XLEN-2:0], 1'b1};

    assign acc_nxt = op_p0[2] ? div_step : mul_step;

    always_ff @(posedge clk) begin
        if (start) begin
            acc_p0   <= {{XLEN{1'b0}}, a_mag};
            dvs_p0   <= b_mag;
            a_p0     <= a;
            op_p0    <= op;
            a_neg_p0 <= a_neg;
            b_neg_p0 <= b_neg;
            dbz_p0   <= (b == '0);
            ovf_p0   <= op[2] && !op[0] && (a == MIN_NEG) && (b == ONES);
        end else if (busy) begin
            acc_p0 <= acc_nxt;
        end
    end

    assign prod = (a_neg_p0 ^ b_neg_p0) ? -acc_nxt : acc_nxt;
    assign quot = (a_neg_p0 ^ b_neg_p0) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    assign rem  = a_neg_p0 ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        result = '0;
        case (op_p0)
            OP_MUL[2:0]:                   result = prod[XLEN-1:0];
            OP_MULH[2:0], OP_MULHSU[2:0],
            OP_MULHU[2:0]:                 result = prod[2*XLEN-1:XLEN];
            OP_DIV[2:0], OP_DIVU[2:0]:     result = dbz_p0 ? ONES : (ovf_p0 ? a_p0 : quot);
            default:                       result = dbz_p0 ? a_p0 : (ovf_p0 ? '0 : rem);
        endcase
    end

endmodule
`endif

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: base ops in one registered cycle; RV32M ops on the
// iterative unit when SEQ_ALU_MDU_EN is defined, otherwise reported illegal.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_DONE = DONE;
`ifdef SEQ_ALU_MDU_EN
    localparam logic [1:0] S_BUSY = BUSY;
`endif

    logic [1:0]             state;
    logic                   accept, mdu_go;
    logic [XLEN-1:0]        base_res, res_q;
    logic                   base_ill, zero_q, ill_q;
    logic signed [XLEN-1:0] a_s, b_s;
    logic [SHW-1:0]         shamt;

    assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = ill_q;

    // flush wins over a same-cycle accept; the presented op is dropped.
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef SEQ_ALU_MDU_EN
    logic            mdu_done;
    logic [XLEN-1:0] mdu_res;

    assign mdu_go = accept && is_mdu(bus.op);

    iter_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (bus.flush),
        .start  (mdu_go),
        .op     (bus.op[2:0]),
        .a      (bus.a),
        .b      (bus.b),
        .done   (mdu_done),
        .result (mdu_res)
    );
`else
    assign mdu_go = 1'b0;
`endif

    assign a_s   = bus.a;
    assign b_s   = bus.b;
    assign shamt = bus.b[SHW-1:0];

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (bus.op)
            OP_ADD:   base_res = bus.a + bus.b;
            OP_SUB:   base_res = bus.a - bus.b;
            OP_AND:   base_res = bus.a & bus.b;
            OP_OR:    base_res = bus.a | bus.b;
            OP_XOR:   base_res = bus.a ^ bus.b;
            OP_PASSA: base_res = bus.a;
            OP_SHL:   base_res = bus.a << shamt;
            OP_SHR:   base_res = bus.a >> shamt;
            OP_SHA:   base_res = a_s >>> shamt;
            OP_SLT:   base_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OP_PASSB: base_res = bus.b;
            default:  base_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            res_q  <= '0;
            zero_q <= 1'b0;
            ill_q  <= 1'b0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept && !mdu_go) begin
                        state  <= S_DONE;
                        res_q  <= base_res;
                        zero_q <= (base_res == '0);
                        ill_q  <= base_ill;
                    end
`ifdef SEQ_ALU_MDU_EN
                    else if (mdu_go) begin
                        state <= S_BUSY;
                    end
`endif
                    else if ((state == S_DONE) && bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
`ifdef SEQ_ALU_MDU_EN
                S_BUSY: begin
                    if (mdu_done) begin
                        state  <= S_DONE;
                        res_q  <= mdu_res;
                        zero_q <= (mdu_res == '0);
                        ill_q  <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against a plain-arithmetic model;
// adapts to SEQ_ALU_MDU_EN.
module tb_seq_alu;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    seq_alu_if #(.XLEN(XLEN)) bus ();
    seq_alu #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: results straight from the operation definitions.
    function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill, output int lat);
        longint      sa, sb;
        logic [63:0] p;
        logic [4:0]  sh;
        logic        ovf;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r = 32'h0; ill = 1'b0; lat = 1; p = 64'h0;
        case (op)
            5'b00000: r = a + b;
            5'b00001: r = a - b;
            5'b00100: r = a & b;
            5'b00101: r = a | b;
            5'b00110: r = a ^ b;
            5'b00111: r = a;
            5'b01000: r = a << sh;
            5'b01010: r = a >> sh;
            5'b01011: r = 32'($signed(a) >>> sh);
            5'b01100: r = (sa < sb) ? 32'd1 : 32'd0;
            5'b01101: r = (a < b) ? 32'd1 : 32'd0;
            5'b01111: r = b;
`ifdef SEQ_ALU_MDU_EN
            5'b10000: begin p = 64'(sa * sb); r = p[31:0]; end
            5'b10001: begin p = 64'(sa * sb); r = p[63:32]; end
            5'b10010: begin p = 64'(sa * longint'({32'h0, b})); r = p[63:32]; end
            5'b10011: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            5'b10100: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            5'b10101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'b10110: r = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            5'b10111: r = (b == 0) ? a : a % b;
`endif
            default: begin r = 32'h0; ill = 1'b1; end
        endcase
`ifdef SEQ_ALU_MDU_EN
        if (op[4]) lat = XLEN + 1;
`endif
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Presents one op, waits for accept, then counts cycles until out_valid.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic ordy,
                         output logic [31:0] res, output logic z, output logic ill, output int lat,
                         output bit quiet);
        int w;
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = ordy;
        w = 0;
        while (!bus.in_ready && w < 64) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 5'($urandom); bus.a = $urandom; bus.b = $urandom;
        lat = 1; quiet = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) quiet = 1'b0;
            @(posedge clk); #1; lat++;
        end
        res = bus.result; z = bus.zero; ill = bus.illegal;
    endtask

    task automatic test_reset();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 5'h0; bus.a = 32'h0; bus.b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b ill=%b want rdy=1 vld=0 res=0 z=0 ill=0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [4:0]  ops [8];
        logic [31:0] as  [8];
        logic [31:0] bs  [8];
        logic [31:0] want [8];
        int          wlat [8];
        logic [31:0] res;
        logic        z, ill;
        int          lat, n;
        bit          quiet;
        ops[0] = 5'b00000; as[0] = 32'hFFFF_FFFF; bs[0] = 32'h1; want[0] = 32'h0;         wlat[0] = 1;
        ops[1] = 5'b01011; as[1] = 32'h8000_0000; bs[1] = 32'h4; want[1] = 32'hF800_0000; wlat[1] = 1;
`ifdef SEQ_ALU_MDU_EN
        ops[2] = 5'b10010; as[2] = 32'hFFFF_FFFF; bs[2] = 32'hFFFF_FFFF; want[2] = 32'hFFFF_FFFF; wlat[2] = 33;
        ops[3] = 5'b10100; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; want[3] = 32'h8000_0000; wlat[3] = 33;
        ops[4] = 5'b10110; as[4] = 32'h8000_0000; bs[4] = 32'hFFFF_FFFF; want[4] = 32'h0;         wlat[4] = 33;
        ops[5] = 5'b10101; as[5] = 32'h7;         bs[5] = 32'h0;         want[5] = 32'hFFFF_FFFF; wlat[5] = 33;
        ops[6] = 5'b10111; as[6] = 32'h7;         bs[6] = 32'h0;         want[6] = 32'h7;         wlat[6] = 33;
        n = 7;
`else
        ops[2] = 5'b10000; as[2] = 32'h3; bs[2] = 32'h4; want[2] = 32'h0; wlat[2] = 1;
        n = 3;
`endif
        drain();
        for (int i = 0; i < n; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1, res, z, ill, lat, quiet);
            total++;
            if (res !== want[i] || z !== (want[i] == 0) || ill !== (ops[i][4] && wlat[i] == 1) ||
                lat != wlat[i] || !quiet) begin
                bad++;
                $display("FAIL directed[%0d] op=%b got res=%h z=%b ill=%b lat=%0d quiet=%b want res=%h lat=%0d",
                         i, ops[i], res, z, ill, lat, quiet, want[i], wlat[i]);
            end
        end
    endtask

    task automatic test_undefined();
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        bit          quiet;
        drain();
        issue(5'b00101, 32'h1234_0000, 32'h0000_5678, 1'b1, res, z, ill, lat, quiet);
        issue(5'b00010, 32'hDEAD_BEEF, 32'h1, 1'b1, res, z, ill, lat, quiet);
        total++;
        if (res !== 32'h0 || z !== 1'b1 || ill !== 1'b1 || lat != 1) begin
            bad++;
            $display("FAIL undefined_op got res=%h z=%b ill=%b lat=%0d want res=0 z=1 ill=1 lat=1", res, z, ill, lat);
        end
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] a, b, res, er;
        logic        z, ill, eill;
        int          lat, elat;
        bit          quiet;
        drain();
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            a = pick_val();
            b = pick_val();
            ref_alu(op, a, b, er, eill, elat);
            issue(op, a, b, 1'b1, res, z, ill, lat, quiet);
            total++;
            if (res !== er || z !== (er == 0) || ill !== eill || lat != elat || !quiet) begin
                bad++;
                $display("FAIL rand[%0d] op=%b a=%h b=%h got res=%h z=%b ill=%b lat=%0d want res=%h ill=%b lat=%0d",
                         i, op, a, b, res, z, ill, lat, er, eill, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  base_ops [12];
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [31:0] er [16];
        logic        eill;
        int          elat;
        base_ops = '{5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                     5'b01000, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01111};
        drain();
        for (int i = 0; i < 16; i++) begin
            op = base_ops[$urandom_range(0, 11)];
            a = pick_val();
            b = pick_val();
            ref_alu(op, a, b, er[i], eill, elat);
            bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            @(posedge clk); #1;
            if (i == 15) bus.in_valid = 1'b0;
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== er[i] || bus.zero !== (er[i] == 0)) begin
                bad++;
                $display("FAIL b2b[%0d] got vld=%b res=%h z=%b want vld=1 res=%h", i, bus.out_valid,
                         bus.result, bus.zero, er[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        bit          quiet;
        drain();
        issue(5'b00000, 32'd10, 32'd20, 1'b0, res, z, ill, lat, quiet);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd30 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d] got vld=%b res=%h rdy=%b want vld=1 res=1e rdy=0", k,
                         bus.out_valid, bus.result, bus.in_ready);
            end
        end
        bus.op = 5'b00000; bus.a = 32'd2; bus.b = 32'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin
            bad++;
            $display("FAIL release_accept got vld=%b res=%h want vld=1 res=5", bus.out_valid, bus.result);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic        z, ill;
        int          lat, seen;
        bit          quiet;
        drain();
        // Flush in IDLE alongside a valid op: the op must be dropped.
        bus.op = 5'b00000; bus.a = 32'd9; bus.b = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_idle got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
`ifdef SEQ_ALU_MDU_EN
        bus.op = 5'b10101; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin
            @(posedge clk); #1;
        end
        bus.op = 5'b00000; bus.a = 32'd9; bus.b = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_busy got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
`endif
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL flush_dropped got out_valid_cycles=%0d want 0", seen);
        end
        issue(5'b00000, 32'd1, 32'd1, 1'b1, res, z, ill, lat, quiet);
        total++;
        if (res !== 32'd2 || lat != 1 || ill !== 1'b0) begin
            bad++;
            $display("FAIL after_flush got res=%h lat=%0d ill=%b want res=2 lat=1 ill=0", res, lat, ill);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        bit          quiet;
        drain();
        issue(5'b00000, 32'd5, 32'd6, 1'b1, res, z, ill, lat, quiet);
`ifdef SEQ_ALU_MDU_EN
        bus.op = 5'b10000; bus.a = 32'd3; bus.b = 32'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
`else
        bus.out_ready = 1'b0;
        issue(5'b00000, 32'd5, 32'd6, 1'b0, res, z, ill, lat, quiet);
`endif
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got rdy=%b vld=%b res=%h z=%b ill=%b want rdy=1 vld=0 res=0 z=0 ill=0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        issue(5'b00000, 32'd1, 32'd2, 1'b1, res, z, ill, lat, quiet);
        total++;
        if (res !== 32'd3 || lat != 1) begin
            bad++;
            $display("FAIL after_reset got res=%h lat=%0d want res=3 lat=1", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_undefined();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
